noc_out_port_arbiter: RTL and testbench
=======================================

Name: noc_out_port_arbiter

Overview:
- Output-port scheduler for one router output: shares a single output link between N_PORTS input circular FIFOs (N-1 usable entries, registered read data).
- Issues one-hot read enables to the FIFOs and captures the flit one cycle after the pop.
- Drives a valid/ready output link.
- Performs round-robin arbitration with wormhole locking, so a packet's flits are never interleaved.

Parameters:
- N_PORTS, 4, number of input FIFOs arbitrated (>=2).
- DATA_W, 8, flit width; bits [DATA_W-1:DATA_W-2] are the flit type, the rest is payload.
- PORT_W, $clog2(N_PORTS), localparam; width of the grant index.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- empty_i  in  N_PORTS  per-FIFO empty flag.
- fifo_data_i  in  N_PORTS*DATA_W  per-FIFO registered read data; port k occupies bits [k*DATA_W +: DATA_W].
- rd_en_o  out  N_PORTS  one-hot pop strobe to the FIFOs.
- data_o  out  DATA_W  output flit.
- valid_o  out  1  output flit valid.
- ready_i  in  1  downstream accepts the flit.
- grant_o  out  PORT_W  index of the port that sourced data_o.
- locked_o  out  1  a packet is in progress (wormhole lock held).
- err_o  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Flit types: HEAD=2'b01, BODY=2'b00, TAIL=2'b10, SINGLE=2'b11.
- Reset (async): state=IDLE; rd_en_o=0 (forced 0 while rst_ni low); data_o=0; valid_o=0; grant_o=0; locked_o=0; err_o=0.
- Round-robin pointer resets to N_PORTS-1, so port 0 has first priority.
- FSM states: IDLE, LOAD, SEND.
- IDLE, request vector:
  - locked: req = ~empty_i & onehot(lock_port).
  - unlocked: req = ~empty_i.
- IDLE, grant:
  - If req != 0: select the first set bit searching upward from rr_ptr+1 with wrap-around.
  - Drive rd_en_o = onehot(sel) combinationally in this cycle; register sel into grant_o; go to LOAD.
  - If req == 0: stay in IDLE with rd_en_o = 0.
- LOAD:
  - rd_en_o = 0.
  - data_o <= fifo_data_i[grant_o]; valid_o <= 1; go to SEND.
- SEND:
  - Hold data_o, valid_o and grant_o stable until ready_i.
  - On valid_o && ready_i: valid_o <= 0 and go to IDLE.
  - On the same edge, update lock state from the sent flit type:
    - HEAD: locked_o <= 1, lock_port <= grant_o.
    - TAIL: locked_o <= 0; rr_ptr <= grant_o.
    - SINGLE: locked_o stays 0; rr_ptr <= grant_o.
    - BODY: no change.
- Latency: FIFO non-empty in IDLE -> valid_o high 2 cycles later. Throughput: one flit per 3 cycles when ready_i is held high.
- Exactly one rd_en_o per flit; never pops an empty FIFO, so FIFO underflow is never caused.
- While locked, other ports are starved even if the locked FIFO is empty; the block waits in IDLE.
- ready_i high while valid_o is low: ignored.
- Reset mid-packet: lock is cleared and any captured flit is dropped; the FIFO pop has already occurred.

Optional Feature:
- Macro: ARB_PKT_CHECK_EN.
- Defined: in LOAD, err_o is set (sticky until reset) if either condition holds:
  - locked and the captured flit is HEAD or SINGLE;
  - unlocked and the captured flit is BODY or TAIL.
- Flow is unaffected; the flit is still forwarded.
- Not defined: err_o is tied 0 and no checker logic is present.

Decomposition:
- Package noc_pkg holds:
  - flit-type constants FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_SINGLE;
  - FLIT_TYPE_W=2;
  - FSM state encodings ARB_IDLE, ARB_LOAD, ARB_SEND.
- Sub-module rr_arbiter (combinational):
  - inputs: req[N_PORTS], ptr[PORT_W];
  - outputs: gnt one-hot, gnt_idx, any.
  - Reused by other router output ports.

Test Plan:
1. Reset release, all empty_i=1 for 10 cycles -> rd_en_o=0, valid_o=0, locked_o=0 throughout.
2. Ports 0 and 2 each hold a SINGLE flit (8'hC5, 8'hCA), ready_i=1:
   - rd_en_o=4'b0001 then 4'b0100;
   - data_o 8'hC5 (grant 0) then 8'hCA (grant 2);
   - 3 cycles apart.
3. Port 1 sends HEAD 8'h41, BODY 8'h02, TAIL 8'h83; port 3 holds SINGLE 8'hFF throughout -> output order 41, 02, 83, FF; locked_o high from the HEAD handshake until the TAIL handshake.
4. ready_i=0 for 5 cycles in SEND -> data_o and grant_o stable, no further rd_en_o; handshake on the 6th cycle -> IDLE next.
5. Assert rst_ni=0 in SEND while locked -> valid_o, locked_o, rd_en_o go low immediately; after release, port 0 wins first.
6. ARB_PKT_CHECK_EN defined, unlocked, port 0 delivers BODY 8'h05 -> err_o=1 from the LOAD edge onward, flit still output; without the macro err_o=0.

Source files
------------

// File: rtl/noc_out_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the router output-port logic.
//   - Flit-type encodings carried in the top FLIT_TYPE_W bits of every flit.
//   - State encoding of the output-port arbiter FSM.
// No ports (package).
// -----------------------------------------------------------------------------
package noc_pkg;

  localparam int FLIT_TYPE_W = 2;

  localparam logic [FLIT_TYPE_W-1:0] FLIT_BODY   = 2'b00;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_HEAD   = 2'b01;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_TAIL   = 2'b10;
  localparam logic [FLIT_TYPE_W-1:0] FLIT_SINGLE = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_LOAD = 2'd1,
    ARB_SEND = 2'd2
  } arb_state_t;

endpackage

// File: rtl/noc_out_port_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker, shared by all router output ports.
// Searches i_req upward starting at i_ptr+1 and wraps around, so the port
// named by i_ptr has the lowest priority.
// Ports:
//   i_req     N_PORTS  request vector
//   i_ptr     PORT_W   last-served port (round-robin pointer)
//   o_gnt     N_PORTS  one-hot grant (all zero when nothing requests)
//   o_gntIdx  PORT_W   binary index of the granted port
//   o_any     1        at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N_PORTS = 4,
  localparam int PORT_W  = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] i_req,
  input  logic [PORT_W-1:0]  i_ptr,
  output logic [N_PORTS-1:0] o_gnt,
  output logic [PORT_W-1:0]  o_gntIdx,
  output logic               o_any
);

  // Walk the ports in priority order (ptr+1, ptr+2, ... wrapping) and take
  // the first requester; o_any doubles as the "already found" flag.
  always_comb begin
    int idx;
    idx      = 0;
    o_gnt    = '0;
    o_gntIdx = '0;
    o_any    = 1'b0;
    for (int off = 1; off <= N_PORTS; off++) begin
      idx = (int'(i_ptr) + off) % N_PORTS;
      if (!o_any && i_req[idx]) begin
        o_any       = 1'b1;
        o_gnt[idx]  = 1'b1;
        o_gntIdx    = PORT_W'(idx);
      end
    end
  end

endmodule

// File: rtl/noc_out_port_arbiter.sv
// -----------------------------------------------------------------------------
// noc_out_port_arbiter
// Shares one router output link between N_PORTS input FIFOs. Each flit takes
// three phases: IDLE (arbitrate and pop the winner), LOAD (capture the FIFO's
// registered read data) and SEND (hold the flit until the link accepts it).
// A HEAD flit locks the link to its port until the matching TAIL, so packets
// are never interleaved (wormhole switching).
// Optional build macro: ARB_PKT_CHECK_EN enables the sticky packet-framing
// checker on err_o; without it err_o is tied low.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   empty_i        per-FIFO empty flags
//   fifo_data_i    per-FIFO read data, port k at [k*DATA_W +: DATA_W]
//   rd_en_o        one-hot FIFO pop strobe
//   data_o         output flit, valid_o / ready_i handshake
//   grant_o        port that sourced data_o
//   locked_o       wormhole lock held
//   err_o          sticky framing error
// -----------------------------------------------------------------------------
module noc_out_port_arbiter
  import noc_pkg::*;
#(
  parameter  int N_PORTS = 4,
  parameter  int DATA_W  = 8,
  localparam int PORT_W  = $clog2(N_PORTS)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_PORTS-1:0]        empty_i,
  input  logic [N_PORTS*DATA_W-1:0] fifo_data_i,
  output logic [N_PORTS-1:0]        rd_en_o,
  output logic [DATA_W-1:0]         data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [PORT_W-1:0]         grant_o,
  output logic                      locked_o,
  output logic                      err_o
);

  arb_state_t               r_state;
  arb_state_t               w_nextState;
  logic [PORT_W-1:0]        r_rrPtr;
  logic [PORT_W-1:0]        r_lockPort;
  logic [PORT_W-1:0]        r_grant;
  logic [DATA_W-1:0]        r_data;
  logic                     r_valid;
  logic                     r_locked;
  logic [N_PORTS-1:0]       w_lockMask;
  logic [N_PORTS-1:0]       w_req;
  logic [N_PORTS-1:0]       w_gnt;
  logic [N_PORTS-1:0]       w_rdEn;
  logic [PORT_W-1:0]        w_gntIdx;
  logic                     w_any;
  logic [DATA_W-1:0]        w_capFlit;
  logic [FLIT_TYPE_W-1:0]   w_capType;
  logic [FLIT_TYPE_W-1:0]   w_sentType;

  // One-hot mask of the port that owns the wormhole lock.
  always_comb begin
    w_lockMask             = '0;
    w_lockMask[r_lockPort] = 1'b1;
  end

  // While locked only the owner may request, even if its FIFO is empty and
  // other ports are waiting; that is what keeps packets contiguous.
  assign w_req = r_locked ? (~empty_i & w_lockMask) : ~empty_i;

  rr_arbiter #(
    .N_PORTS (N_PORTS)
  ) u_rrArbiter (
    .i_req    (w_req),
    .i_ptr    (r_rrPtr),
    .o_gnt    (w_gnt),
    .o_gntIdx (w_gntIdx),
    .o_any    (w_any)
  );

  assign w_capFlit  = fifo_data_i[r_grant*DATA_W +: DATA_W];
  assign w_capType  = w_capFlit[DATA_W-1 -: FLIT_TYPE_W];
  assign w_sentType = r_data[DATA_W-1 -: FLIT_TYPE_W];

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and pop strobe. The pop is issued in IDLE so that the FIFO's
  // registered read data is ready to capture in LOAD.
  always_comb begin
    w_nextState = r_state;
    w_rdEn      = '0;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_rdEn      = w_gnt;
          w_nextState = ARB_LOAD;
        end
      end
      ARB_LOAD: begin
        w_nextState = ARB_SEND;
      end
      ARB_SEND: begin
        if (r_valid && ready_i) begin
          w_nextState = ARB_IDLE;
        end
      end
      default: begin
        w_nextState = ARB_IDLE;
      end
    endcase
  end

  // Datapath: remember the winner, capture its flit, and on the accepting
  // handshake update the wormhole lock and the round-robin pointer. The
  // pointer only moves at packet end so a locked packet cannot skew fairness.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rrPtr    <= PORT_W'(N_PORTS - 1);
      r_lockPort <= '0;
      r_grant    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_grant <= w_gntIdx;
          end
        end
        ARB_LOAD: begin
          r_data  <= w_capFlit;
          r_valid <= 1'b1;
        end
        ARB_SEND: begin
          if (r_valid && ready_i) begin
            r_valid <= 1'b0;
            case (w_sentType)
              FLIT_HEAD: begin
                r_locked   <= 1'b1;
                r_lockPort <= r_grant;
              end
              FLIT_TAIL: begin
                r_locked <= 1'b0;
                r_rrPtr  <= r_grant;
              end
              FLIT_SINGLE: begin
                r_rrPtr <= r_grant;
              end
              default: begin
              end
            endcase
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ARB_PKT_CHECK_EN
  logic r_err;
  logic w_frameErr;

  // A new packet may not start inside a locked packet, and a continuation
  // flit may not appear outside one. Only flagged; the flit still goes out.
  always_comb begin
    w_frameErr = 1'b0;
    if (r_locked) begin
      w_frameErr = (w_capType == FLIT_HEAD) || (w_capType == FLIT_SINGLE);
    end else begin
      w_frameErr = (w_capType == FLIT_BODY) || (w_capType == FLIT_TAIL);
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if ((r_state == ARB_LOAD) && w_frameErr) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  // The pop strobe is combinational from empty_i, so it is gated by reset to
  // keep the FIFOs untouched while rst_ni is low.
  assign rd_en_o  = w_rdEn & {N_PORTS{rst_ni}};
  assign data_o   = r_data;
  assign valid_o  = r_valid;
  assign grant_o  = r_grant;
  assign locked_o = r_locked;

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_noc_out_port_arbiter
// Self-checking bench for noc_out_port_arbiter. Behavioural FIFOs feed the
// DUT; a transaction-level reference model predicts every pop, every flit on
// the link, the lock flag and the error flag from the scheduling rules.
// Honours ARB_PKT_CHECK_EN for the expected err_o.
// -----------------------------------------------------------------------------
module tb_noc_out_port_arbiter;

  localparam int N_PORTS = 4;
  localparam int DATA_W  = 8;
  localparam int PORT_W  = 2;
  localparam int DEPTH   = 256;

  logic                      clk_i = 1'b0;
  logic                      rst_ni;
  logic [N_PORTS-1:0]        empty_i;
  logic [N_PORTS*DATA_W-1:0] fifo_data_i;
  logic [N_PORTS-1:0]        rd_en_o;
  logic [DATA_W-1:0]         data_o;
  logic                      valid_o;
  logic                      ready_i;
  logic [PORT_W-1:0]         grant_o;
  logic                      locked_o;
  logic                      err_o;

  // Behavioural input FIFOs: storage, counters and registered read data.
  logic [DATA_W-1:0] fifoMem [N_PORTS][DEPTH];
  int                wrCnt   [N_PORTS];
  int                rdCnt   [N_PORTS];
  logic [DATA_W-1:0] fifoOut [N_PORTS];

  // Reference model state.
  logic        mBusy, mInLoad, mLocked, mErr, mPendErr;
  int          mRr, mLockPort, mPort;
  logic [7:0]  mFlit;
  int          cycle;

  // Observed link handshakes.
  logic [7:0]  hsData[$];
  int          hsGrant[$];
  int          hsCycle[$];

  int errCount   = 0;
  int checkCount = 0;

  noc_out_port_arbiter #(
    .N_PORTS (N_PORTS),
    .DATA_W  (DATA_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .empty_i     (empty_i),
    .fifo_data_i (fifo_data_i),
    .rd_en_o     (rd_en_o),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .grant_o     (grant_o),
    .locked_o    (locked_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  for (genvar k = 0; k < N_PORTS; k++) begin : g_fifo
    assign empty_i[k]                        = (wrCnt[k] == rdCnt[k]);
    assign fifo_data_i[k*DATA_W +: DATA_W]   = fifoOut[k];
  end

  // Compare one observed value with its expected value and log mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)",
               tag, observed, expected, cycle);
    end
  endtask

  task automatic pushFlit(input int port, input logic [7:0] flit);
    fifoMem[port][wrCnt[port] % DEPTH] = flit;
    wrCnt[port]++;
  endtask

  // Random legal packet: SINGLE, or HEAD + BODY* + TAIL.
  task automatic pushPacket(input int port);
    int         len;
    logic [5:0] pl;
    logic [1:0] ty;
    len = int'($urandom_range(1, 4));
    for (int i = 0; i < len; i++) begin
      pl = 6'($urandom);
      if (len == 1)          ty = 2'b11;
      else if (i == 0)       ty = 2'b01;
      else if (i == len - 1) ty = 2'b10;
      else                   ty = 2'b00;
      pushFlit(port, {ty, pl});
    end
  endtask

  function automatic bit anyPending();
    bit p;
    p = 1'b0;
    for (int k = 0; k < N_PORTS; k++) if (wrCnt[k] != rdCnt[k]) p = 1'b1;
    return p;
  endfunction

  function automatic void clearLog();
    hsData.delete();
    hsGrant.delete();
    hsCycle.delete();
  endfunction

  // One clock cycle: apply ready, check every output against the model at
  // the falling edge, then advance FIFOs and model past the rising edge.
  task automatic applyStimulus(input logic rdy);
    logic [N_PORTS-1:0] nonEmpty, elig, expRd, obsRd;
    logic               expValid, hs;
    int                 idx;
    ready_i = rdy;
    @(negedge clk_i);
    nonEmpty = '0;
    elig     = '0;
    expRd    = '0;
    for (int k = 0; k < N_PORTS; k++) nonEmpty[k] = (wrCnt[k] != rdCnt[k]);
    if (!mBusy) begin
      elig = nonEmpty;
      if (mLocked) begin
        elig            = '0;
        elig[mLockPort] = nonEmpty[mLockPort];
      end
      for (int off = 1; off <= N_PORTS; off++) begin
        idx = (mRr + off) % N_PORTS;
        if (expRd == '0 && elig[idx]) expRd[idx] = 1'b1;
      end
    end
    obsRd = rd_en_o;
    checkOutput("rd_en", 32'(obsRd), 32'(expRd));
    expValid = mBusy && !mInLoad;
    checkOutput("valid", 32'(valid_o), 32'(expValid));
    if (expValid) begin
      checkOutput("data", 32'(data_o), 32'(mFlit));
      checkOutput("grant", 32'(grant_o), 32'(mPort));
    end
    checkOutput("locked", 32'(locked_o), 32'(mLocked));
    checkOutput("err", 32'(err_o), 32'(mErr));
    hs = expValid && rdy;
    if (hs) begin
      hsData.push_back(data_o);
      hsGrant.push_back(int'(grant_o));
      hsCycle.push_back(cycle);
    end

    @(posedge clk_i);
    #1;
    cycle++;
    if (mInLoad) begin
      mInLoad = 1'b0;
      mErr    = mErr | mPendErr;
    end
    if (hs) begin
      mBusy = 1'b0;
      case (mFlit[7:6])
        2'b01: begin mLocked = 1'b1; mLockPort = mPort; end
        2'b10: begin mLocked = 1'b0; mRr = mPort; end
        2'b11: mRr = mPort;
        default: ;
      endcase
    end
    if (expRd != '0) begin
      for (int k = 0; k < N_PORTS; k++) if (expRd[k]) mPort = k;
      mFlit   = fifoMem[mPort][rdCnt[mPort] % DEPTH];
      mBusy   = 1'b1;
      mInLoad = 1'b1;
`ifdef ARB_PKT_CHECK_EN
      mPendErr = mLocked ? (mFlit[7:6] == 2'b01 || mFlit[7:6] == 2'b11)
                         : (mFlit[7:6] == 2'b00 || mFlit[7:6] == 2'b10);
`else
      mPendErr = 1'b0;
`endif
    end
    for (int k = 0; k < N_PORTS; k++) begin
      if (obsRd[k] && (wrCnt[k] != rdCnt[k])) begin
        fifoOut[k] = fifoMem[k][rdCnt[k] % DEPTH];
        rdCnt[k]++;
      end
    end
  endtask

  // Run until all FIFOs are drained and the link is idle, with a cycle bound.
  task automatic runUntilIdle(input int maxCycles, input logic randomReady,
                              input string tag);
    int n;
    n = 0;
    while ((anyPending() || mBusy) && n < maxCycles) begin
      applyStimulus(randomReady ? ($urandom_range(0, 3) != 0) : 1'b1);
      n++;
    end
    checkOutput({tag, "_drained"}, 32'(anyPending() || mBusy), 32'd0);
  endtask

  // Asynchronous reset: outputs must drop at once, before any clock edge.
  task automatic resetDut();
    rst_ni = 1'b0;
    #1;
    checkOutput("rst_rd_en", 32'(rd_en_o), 32'd0);
    checkOutput("rst_valid", 32'(valid_o), 32'd0);
    checkOutput("rst_locked", 32'(locked_o), 32'd0);
    checkOutput("rst_data", 32'(data_o), 32'd0);
    checkOutput("rst_grant", 32'(grant_o), 32'd0);
    checkOutput("rst_err", 32'(err_o), 32'd0);
    for (int k = 0; k < N_PORTS; k++) begin
      rdCnt[k]   = wrCnt[k];
      fifoOut[k] = '0;
    end
    mBusy = 1'b0; mInLoad = 1'b0; mLocked = 1'b0; mErr = 1'b0; mPendErr = 1'b0;
    mRr = N_PORTS - 1; mLockPort = 0; mPort = 0; mFlit = '0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] exp3 [4];
    int         startCycle;
    rst_ni  = 1'b1;
    ready_i = 1'b0;
    cycle   = 0;
    for (int k = 0; k < N_PORTS; k++) begin
      wrCnt[k] = 0; rdCnt[k] = 0; fifoOut[k] = '0;
    end
    #2;
    // A waiting flit during reset must not be popped.
    pushFlit(2, 8'hC1);
    resetDut();

    $display("[TB] idle with all FIFOs empty");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1);

    $display("[TB] two SINGLE flits on ports 0 and 2");
    clearLog();
    pushFlit(0, 8'hC5);
    pushFlit(2, 8'hCA);
    runUntilIdle(20, 1'b0, "t2");
    checkOutput("t2_count", 32'(hsData.size()), 32'd2);
    if (hsData.size() >= 2) begin
      checkOutput("t2_first_data", 32'(hsData[0]), 32'hC5);
      checkOutput("t2_first_grant", 32'(hsGrant[0]), 32'd0);
      checkOutput("t2_second_data", 32'(hsData[1]), 32'hCA);
      checkOutput("t2_second_grant", 32'(hsGrant[1]), 32'd2);
      checkOutput("t2_spacing", 32'(hsCycle[1] - hsCycle[0]), 32'd3);
    end

    $display("[TB] wormhole packet on port 1 against SINGLE on port 3");
    resetDut();
    clearLog();
    pushFlit(1, 8'h41);
    pushFlit(1, 8'h02);
    pushFlit(1, 8'h83);
    pushFlit(3, 8'hFF);
    runUntilIdle(40, 1'b0, "t3");
    exp3[0] = 8'h41; exp3[1] = 8'h02; exp3[2] = 8'h83; exp3[3] = 8'hFF;
    checkOutput("t3_count", 32'(hsData.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < hsData.size()) checkOutput("t3_order", 32'(hsData[i]), 32'(exp3[i]));
    end

    $display("[TB] back-pressure for 5 cycles in SEND");
    clearLog();
    pushFlit(2, 8'hD7);
    pushFlit(0, 8'hC3);
    startCycle = cycle;
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0);
    applyStimulus(1'b1);
    runUntilIdle(20, 1'b0, "t4");
    checkOutput("t4_count", 32'(hsData.size()), 32'd2);
    if (hsData.size() >= 2) begin
      checkOutput("t4_first_data", 32'(hsData[0]), 32'hC3);
      checkOutput("t4_hs_cycle", 32'(hsCycle[0] - startCycle), 32'd7);
      checkOutput("t4_second_data", 32'(hsData[1]), 32'hD7);
    end

    $display("[TB] reset while a locked packet is in SEND");
    resetDut();
    clearLog();
    pushFlit(1, 8'h4A);
    runUntilIdle(20, 1'b0, "t5a");
    checkOutput("t5_locked_before", 32'(locked_o), 32'd1);
    pushFlit(1, 8'h0B);
    pushFlit(3, 8'hFE);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0);
    checkOutput("t5_valid_before", 32'(valid_o), 32'd1);
    resetDut();
    clearLog();
    pushFlit(3, 8'hF3);
    pushFlit(0, 8'hC0);
    runUntilIdle(20, 1'b0, "t5b");
    if (hsGrant.size() >= 1) checkOutput("t5_first_grant", 32'(hsGrant[0]), 32'd0);
    else checkOutput("t5_count", 32'(hsGrant.size()), 32'd2);

    $display("[TB] randomized packets with random back-pressure");
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N_PORTS; k++) begin
        int np;
        np = int'($urandom_range(0, 3));
        for (int p = 0; p < np; p++) pushPacket(k);
      end
      runUntilIdle(800, 1'b1, "rand");
    end

    $display("[TB] unexpected BODY flit while unlocked");
    clearLog();
    pushFlit(0, 8'h05);
    runUntilIdle(20, 1'b0, "t6");
    if (hsData.size() >= 1) checkOutput("t6_data", 32'(hsData[0]), 32'h05);
    else checkOutput("t6_count", 32'(hsData.size()), 32'd1);
`ifdef ARB_PKT_CHECK_EN
    checkOutput("t6_err", 32'(err_o), 32'd1);
`else
    checkOutput("t6_err", 32'(err_o), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
